debug_cmd_sync_queue: RTL

Next-generation sysclk-side half of the debug slave. It takes the JTAG-domain scan register and update strobes and synchronizes them into the system clock. Each completed DR update is queued as a {ir, sr} command in a small FIFO, and commands are presented downstream with a valid/ready handshake plus a one-hot action strobe. It replaces the fixed-width, unbuffered decode, so back-to-back JTAG updates are no longer lost while the CPU-side consumer is busy.

---
 rtl/debug_cmd_sync_queue_pkg.sv | 20 ++
 rtl/debug_edge_sync.sv | 36 +++
 rtl/debug_cmd_sync_queue.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/debug_cmd_sync_queue_pkg.sv
// Shared definitions for the sysclk-side debug command queue.
// Holds the virtual IR codes, the default scan widths and the FIFO entry width helper.
package debug_cmd_sync_queue_pkg;

  parameter int unsigned DEF_SR_W = 38;
  parameter int unsigned DEF_IR_W = 2;

  typedef enum logic [1:0] {
    IR_OCIMEM    = 2'd0,
    IR_TRACEMEM  = 2'd1,
    IR_BREAK     = 2'd2,
    IR_TRACECTRL = 2'd3
  } ir_code_e;

  // One queued command is {ir, sr}.
  function automatic int unsigned entry_width(int unsigned ir_w, int unsigned sr_w);
    return ir_w + sr_w;
  endfunction

endpackage

// File: rtl/debug_edge_sync.sv
// Level synchronizer with rising-edge detect.
// Ports:
//   clk_i    - destination clock
//   rst_ni   - asynchronous active-low reset
//   level_i  - asynchronous level input
//   pulse_o  - one-cycle pulse per synchronized rising level
module debug_edge_sync #(
  parameter int unsigned SyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic level_i,
  output logic pulse_o
);

  logic [SyncStages-1:0] sync_q, sync_d;
  logic                  prev_q;

  always_comb begin
    sync_d = {sync_q[SyncStages-2:0], level_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= sync_q[SyncStages-1];
    end
  end

  // prev_q resets to 0, so a level held across reset release still yields one pulse.
  assign pulse_o = sync_q[SyncStages-1] & ~prev_q;

endmodule

// File: rtl/debug_cmd_sync_queue.sv
// Sysclk-side half of the debug slave: synchronizes JTAG update strobes, queues each
// DR update as an {ir, sr} command and presents it with valid/ready plus an action strobe.
// Ports:
//   clk, reset_n           - system clock, async active-low reset
//   ir_in, sr              - TCK-domain virtual IR and scan register (quasi-static)
//   vs_udr, vs_uir         - TCK-domain update-DR / update-IR levels
//   cmd_valid/cmd_ready    - head-of-queue handshake; jdo/cmd_ir show the head entry
//   act_strobe             - registered one-hot pulse of the popped command's IR
//   ir_latched             - ir_in captured on each update-IR event
//   fill                   - entry count
//   overflow/overflow_clr  - sticky dropped-update flag and its clear
module debug_cmd_sync_queue
  import debug_cmd_sync_queue_pkg::*;
#(
  parameter int unsigned SR_W        = DEF_SR_W,
  parameter int unsigned IR_W        = DEF_IR_W,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [IR_W-1:0]          ir_in,
  input  logic [SR_W-1:0]          sr,
  input  logic                     vs_udr,
  input  logic                     vs_uir,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [SR_W-1:0]          jdo,
  output logic [IR_W-1:0]          cmd_ir,
  output logic [(1<<IR_W)-1:0]     act_strobe,
  output logic [IR_W-1:0]          ir_latched,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     overflow,
  input  logic                     overflow_clr
);

  localparam int unsigned EntW  = entry_width(IR_W, SR_W);
  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned FillW = PtrW + 1;
  localparam int unsigned ActW  = 1 << IR_W;

  logic udr_evt, uir_evt;

  debug_edge_sync #(
    .SyncStages(SYNC_STAGES)
  ) u_sync_udr (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .level_i(vs_udr),
    .pulse_o(udr_evt)
  );

  debug_edge_sync #(
    .SyncStages(SYNC_STAGES)
  ) u_sync_uir (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .level_i(vs_uir),
    .pulse_o(uir_evt)
  );

  logic [EntW-1:0]  mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FillW-1:0] fill_q, fill_d;
  logic [ActW-1:0]  act_q, act_d;
  logic [IR_W-1:0]  ir_lat_q, ir_lat_d;
  logic             ovf_q, ovf_d;

  logic            full, pop, push_ok, drop;
  logic [EntW-1:0] head;
  logic [IR_W-1:0] head_ir;

  assign head    = mem_q[rd_ptr_q];
  assign head_ir = head[EntW-1 -: IR_W];

  assign cmd_valid = (fill_q != '0);
  assign full      = (fill_q == FillW'(DEPTH));
  assign pop       = cmd_valid & cmd_ready;
  // A pop on the same edge frees the slot, so a push into a full queue still succeeds.
  assign push_ok   = udr_evt & (~full | pop);
  assign drop      = udr_evt & full & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    act_d    = '0;
    ir_lat_d = ir_lat_q;
    ovf_d    = ovf_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop) begin
      rd_ptr_d       = rd_ptr_q + PtrW'(1);
      act_d[head_ir] = 1'b1;
    end

    case ({push_ok, pop})
      2'b10:   fill_d = fill_q + FillW'(1);
      2'b01:   fill_d = fill_q - FillW'(1);
      default: fill_d = fill_q;
    endcase

    if (uir_evt) ir_lat_d = ir_in;

    // Set has priority over clear.
    if (drop)              ovf_d = 1'b1;
    else if (overflow_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      act_q    <= '0;
      ir_lat_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      act_q    <= act_d;
      ir_lat_q <= ir_lat_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset; the outputs are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {ir_in, sr};
  end

  assign jdo        = cmd_valid ? head[SR_W-1:0] : '0;
  assign cmd_ir     = cmd_valid ? head_ir : '0;
  assign act_strobe = act_q;
  assign ir_latched = ir_lat_q;
  assign fill       = fill_q;
  assign overflow   = ovf_q;

endmodule
